jk_cmd_sequencer: RTL and testbench
===================================

# jk_cmd_sequencer

Command-driven stimulus stage that sits directly upstream of the gate-level JK master-slave flip-flop. It drives the flop's `j`/`k` inputs from a small FIFO of commands (hold, reset, set, toggle, each with a repeat length) and keeps a reference model of the flop's state. It compares the flop's returned `q` against that model every cycle and reports mismatches, so the flop can run in-system with a built-in self check.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, at least 2.
- `LEN_W`, 4: width of the per-command repeat field.
- `clk` in 1: single clock; all state updates on the rising edge.
- `cl` in 1: synchronous, active-low reset. The same net drives the flop's clear.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO can accept; equals not-full.
- `cmd_op` in 2: operation; 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
- `cmd_len` in LEN_W: operation repeats for `cmd_len`+1 consecutive cycles.
- `j`, `k` out 1 each: registered drive to the flop.
- `q_in` in 1: flop `q` output.
- `busy` out 1: FSM in DRIVE or FIFO not empty.
- `exp_q` out 1: model state.
- `err` out 1: sticky mismatch flag.
- `err_cnt` out 8: mismatch count; saturates at 255.

## Operation
- Reset (`cl`=0 at an edge) has these effects:
  - Outputs: `j`=`k`=0, `exp_q`=0, `err`=0, `err_cnt`=0, `busy`=0, `cmd_ready`=0.
  - Internal: FIFO emptied, FSM forced to IDLE, `chk_arm`=0.
  - Reset asserted in the middle of a command discards the remainder of that command and all queued commands.
- The first edge with `cl`=1 sets `cmd_ready`=1 and `chk_arm`=1.
- Push: a command is accepted when `cmd_valid`&`cmd_ready` at an edge. When the FIFO is full, `cmd_ready`=0 and the offered command is not accepted; the offerer holds it.
- FSM states:
  - IDLE: if the FIFO is not empty, pop the head, load `op`, load `rem`=`cmd_len`, drive `j`/`k` from `op`, and go to DRIVE. Otherwise hold `j`=`k`=0.
  - DRIVE: `j`/`k` stay at the current op.
    - If `rem`≠0, decrement `rem`.
    - If `rem`=0 and the FIFO is not empty, pop the next command in the same edge (back-to-back, no gap cycle).
    - If `rem`=0 and the FIFO is empty, go to IDLE with `j`=`k`=0.
- Simultaneous push and pop in one edge are both performed; occupancy is unchanged. A pop from an empty FIFO never occurs. A push into a full FIFO never occurs.
- Model update, computed at every edge with `cl`=1 from the current `j`/`k`: `exp_q_next` is as follows.
  - j=0,k=0: `exp_q`.
  - j=0,k=1: 0.
  - j=1,k=0: 1.
  - j=1,k=1: ~`exp_q`.
  - `exp_q` <= `exp_q_next`.
- Check: at each edge with `cl`=1 and `chk_arm`=1, compare `q_in` with `exp_q_next`. On a mismatch, set `err` to 1 (sticky until reset) and increment `err_cnt`, saturating at 255.

## Timing
- Command latency: a command pushed at edge N into an empty FIFO with the FSM in IDLE pops at N+1, so `j`/`k` are valid from N+1. It occupies exactly `cmd_len`+1 cycles.
- Flop relationship: `j`/`k` change just after a rising edge, the flop's master samples them during the high phase, and the slave updates on the falling edge. The effect of the cycle-t drive is therefore visible on `q_in` at edge t+1. That is the edge at which `exp_q_next` is compared against `q_in`.
- Each TOGGLE cycle toggles exactly once.
- `cmd_ready` and `busy` are registered.
- `err` asserts the edge after the mismatch sample.
- `err_cnt` wrap-around is forbidden; it holds at 255.

## Structure
- Shared package `jk_seq_pkg` holds:
  - the `jk_op_t` enum (HOLD/RESET/SET/TOGGLE with the encodings above);
  - the FSM state enum (IDLE, DRIVE);
  - the function `jk_next(q,j,k)`, which the checker and the bench reference model both use.
- Sub-module `jk_cmd_fifo` is a synchronous FIFO, `DEPTH`×(2+`LEN_W`), with pointers one bit wider for full/empty detection, the same `clk`/`cl`, and push/pop/full/empty ports.
- The top level contains the FSM, repeat counter, j/k registers, model and checker. It totals 150–250 lines.

## Test plan
- Reset then idle: after `cl` is released, hold 10 cycles with a correct flop → `j`=`k`=0, `exp_q`=0, `err`=0, `busy`=0, `cmd_ready`=1.
- Set/toggle sequence:
  - Stimulus: push SET len0, TOGGLE len2, RESET len0, with the real flop attached.
  - `j`/`k` = 10, 11, 11, 11, 01 on five consecutive cycles.
  - `exp_q` = 1, 0, 1, 0, 0.
  - `err`=0.
- Back-to-back and full FIFO: push 5 commands while `cmd_ready` is held low by a full FIFO → `cmd_ready`=0 once 4 are queued; the 5th is accepted after the first pop; there are no gap cycles between commands.
- Fault injection: force `q_in` to 0 during SET len3 → `err`=1 on the first affected edge and `err_cnt`=4; `err` stays 1 afterwards.
- Saturation: sustain a stuck `q_in` over 300 mismatching cycles → `err_cnt`=255 and holds.
- Reset mid-command: assert `cl`=0 during TOGGLE len15 at cycle 5 with 2 commands queued → next edge `j`=`k`=0, FIFO empty, `exp_q`=0; after release, `busy`=0.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared types and the JK next-state rule used by the sequencer's checker and its reference model.
package jk_seq_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        RESET  = 2'b01,
        SET    = 2'b10,
        TOGGLE = 2'b11
    } jk_op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } seq_state_t;

    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic q_next;
        case ({j, k})
            2'b00:   q_next = q;
            2'b01:   q_next = 1'b0;
            2'b10:   q_next = 1'b1;
            default: q_next = ~q;
        endcase
        return q_next;
    endfunction

endpackage

// File: rtl/jk_cmd_sequencer_if.sv
// Command handshake bus into the JK sequencer: valid/ready plus opcode and repeat length.
interface jk_cmd_sequencer_if #(
    parameter int LEN_W = 4
) ();
    import jk_seq_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    jk_op_t           cmd_op;
    logic [LEN_W-1:0] cmd_len;

    modport master (output cmd_valid, cmd_op, cmd_len, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_len, output cmd_ready);

endinterface

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra bit so full and empty are distinguishable.
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             cl,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             full_next,
    output logic             empty_next
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr, wptr_next, rptr_next;

    always_comb begin
        wptr_next = push ? wptr + 1'b1 : wptr;
        rptr_next = pop  ? rptr + 1'b1 : rptr;
    end

    assign empty      = (wptr == rptr);
    assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty_next = (wptr_next == rptr_next);
    assign full_next  = (wptr_next[AW] != rptr_next[AW]) &&
                        (wptr_next[AW-1:0] == rptr_next[AW-1:0]);
    assign rdata      = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!cl) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr_next;
            rptr <= rptr_next;
        end
    end

    // Storage needs no clear: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Drives a JK flop's j/k from queued commands and checks its q against an internal
// model of the flop, counting mismatches.
module jk_cmd_sequencer
    import jk_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic                 clk,
    input  logic                 cl,
    jk_cmd_sequencer_if.slave    cmd,
    output logic                 j,
    output logic                 k,
    input  logic                 q_in,
    output logic                 busy,
    output logic                 exp_q,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    localparam int CMD_W = 2 + LEN_W;

    seq_state_t       state, state_next;
    logic [LEN_W-1:0] rem, rem_next;
    logic             j_next, k_next;
    logic             push, pop;
    logic [CMD_W-1:0] head;
    jk_op_t           head_op;
    logic [LEN_W-1:0] head_len;
    logic             full, empty, full_next, empty_next;
    logic             chk_arm;
    logic             exp_q_next;
    logic             mismatch;

    assign push     = cmd.cmd_valid && cmd.cmd_ready && !full;
    assign head_op  = jk_op_t'(head[CMD_W-1 -: 2]);
    assign head_len = head[LEN_W-1:0];

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk        (clk),
        .cl         (cl),
        .push       (push),
        .pop        (pop),
        .wdata      ({cmd.cmd_op, cmd.cmd_len}),
        .rdata      (head),
        .full       (full),
        .empty      (empty),
        .full_next  (full_next),
        .empty_next (empty_next)
    );

    // j/k hold the current op directly (op bit 1 = j, bit 0 = k), so no separate op register.
    always_comb begin
        state_next = state;
        rem_next   = rem;
        j_next     = j;
        k_next     = k;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                j_next = 1'b0;
                k_next = 1'b0;
                if (!empty) begin
                    pop        = 1'b1;
                    rem_next   = head_len;
                    j_next     = head_op[1];
                    k_next     = head_op[0];
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (rem != '0) begin
                    rem_next = rem - 1'b1;
                end else if (!empty) begin
                    pop      = 1'b1;
                    rem_next = head_len;
                    j_next   = head_op[1];
                    k_next   = head_op[0];
                end else begin
                    j_next     = 1'b0;
                    k_next     = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!cl) begin
            state <= IDLE;
            rem   <= '0;
            j     <= 1'b0;
            k     <= 1'b0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
            j     <= j_next;
            k     <= k_next;
        end
    end

    // The drive of cycle t lands on q_in by edge t+1, which is when exp_q_next describes it.
    assign exp_q_next = jk_next(exp_q, j, k);
    assign mismatch   = chk_arm && (q_in != exp_q_next);

    always_ff @(posedge clk) begin
        if (!cl) begin
            exp_q         <= 1'b0;
            chk_arm       <= 1'b0;
            err           <= 1'b0;
            err_cnt       <= '0;
            busy          <= 1'b0;
            cmd.cmd_ready <= 1'b0;
        end else begin
            exp_q         <= exp_q_next;
            chk_arm       <= 1'b1;
            busy          <= (state_next == DRIVE) || !empty_next;
            cmd.cmd_ready <= !full_next;
            if (mismatch) begin
                err <= 1'b1;
                if (err_cnt != ERR_CNT_MAX) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: behavioural JK flop on q_in, stream-level reference model,
// one task per scenario.
module tb_jk_cmd_sequencer;
    import jk_seq_pkg::*;

    localparam int DEPTH = 4;
    localparam int LEN_W = 4;

    logic       clk = 1'b0;
    logic       cl  = 1'b0;
    logic       j, k, q_in, busy, exp_q, err;
    logic [7:0] err_cnt;
    logic       flop_q = 1'b0;
    logic       force_en = 1'b0;
    logic       force_val = 1'b0;

    jk_cmd_sequencer_if #(.LEN_W(LEN_W)) cmd_bus ();

    jk_cmd_sequencer #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk     (clk),
        .cl      (cl),
        .cmd     (cmd_bus),
        .j       (j),
        .k       (k),
        .q_in    (q_in),
        .busy    (busy),
        .exp_q   (exp_q),
        .err     (err),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    // Master-slave JK flop: slave output changes on the falling edge, cleared by cl.
    always @(negedge clk) begin
        if (!cl) flop_q <= 1'b0;
        else     flop_q <= jk_next(flop_q, j, k);
    end
    assign q_in = force_en ? force_val : flop_q;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: each accepted command becomes len+1 drive slots in a stream.
    typedef struct packed {
        logic [1:0] op;
        logic [7:0] left;
        logic       started;
    } mcmd_t;

    mcmd_t      mq [$];
    mcmd_t      m_head;
    logic [5:0] drv_q [$];
    logic       m_j = 0, m_k = 0, m_exp = 0, m_err = 0, m_busy = 0, m_ready = 0, m_arm = 0;
    logic       m_accept = 0, m_acc_now = 0, m_nxt = 0, m_consumed = 0;
    logic [7:0] m_cnt = 0;
    int         m_occ = 0;

    always @(posedge clk) begin
        m_accept = 1'b0;
        if (!cl) begin
            mq.delete();
            m_j = 0; m_k = 0; m_exp = 0; m_err = 0; m_cnt = 0;
            m_arm = 0; m_ready = 0; m_busy = 0;
        end else begin
            m_acc_now = (cmd_bus.cmd_valid === 1'b1) && m_ready;
            m_nxt = jk_next(m_exp, m_j, m_k);
            if (m_arm && (q_in !== m_nxt)) begin
                m_err = 1'b1;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            end
            m_exp = m_nxt;
            m_consumed = 1'b0;
            m_j = 1'b0;
            m_k = 1'b0;
            if (mq.size() != 0) begin
                m_head = mq[0];
                m_j = m_head.op[1];
                m_k = m_head.op[0];
                m_head.left = m_head.left - 8'd1;
                m_head.started = 1'b1;
                if (m_head.left == 8'd0) void'(mq.pop_front());
                else mq[0] = m_head;
                m_consumed = 1'b1;
            end
            if (m_acc_now) begin
                mq.push_back('{op: cmd_bus.cmd_op, left: {4'd0, cmd_bus.cmd_len} + 8'd1, started: 1'b0});
                m_accept = 1'b1;
            end
            m_occ = 0;
            foreach (mq[i]) if (!mq[i].started) m_occ++;
            m_ready = (m_occ != DEPTH);
            m_busy  = m_consumed || (m_occ != 0);
            m_arm   = 1'b1;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        if (m_accept && drv_q.size() != 0) void'(drv_q.pop_front());
        if (drv_q.size() != 0) begin
            cmd_bus.cmd_valid = 1'b1;
            cmd_bus.cmd_op    = jk_op_t'(drv_q[0][5:4]);
            cmd_bus.cmd_len   = drv_q[0][3:0];
        end else begin
            cmd_bus.cmd_valid = 1'b0;
        end
        cyc++;
    endtask

    task automatic do_reset();
        cl = 1'b0;
        force_en = 1'b0;
        drv_q.delete();
        cmd_bus.cmd_valid = 1'b0;
        cycle();
        cycle();
        cl = 1'b1;
    endtask

    task automatic test_reset();
        cl = 1'b0;
        cycle();
        cycle();
        n_vec++;
        if ({j, k, exp_q, err, busy, cmd_bus.cmd_ready, err_cnt} !== 14'd0) begin
            n_err++;
            $display("[TB] FAIL reset_state got %b required all zero",
                     {j, k, exp_q, err, busy, cmd_bus.cmd_ready, err_cnt});
        end
        cl = 1'b1;
        cycle();
        n_vec++;
        if (cmd_bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL first_release got rdy=%b busy=%b required rdy=1 busy=0",
                     cmd_bus.cmd_ready, busy);
        end
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_vec++;
            if ({j, k, exp_q, err, busy, cmd_bus.cmd_ready, err_cnt} !==
                {m_j, m_k, m_exp, m_err, m_busy, m_ready, m_cnt}) begin
                n_err++;
                $display("[TB] FAIL idle_model cyc=%0d got jkqebr=%b cnt=%0d required jkqebr=%b cnt=%0d",
                         cyc, {j, k, exp_q, err, busy, cmd_bus.cmd_ready}, err_cnt,
                         {m_j, m_k, m_exp, m_err, m_busy, m_ready}, m_cnt);
            end
        end
        n_vec++;
        if ({j, k, exp_q, err, busy, cmd_bus.cmd_ready} !== 6'b000001) begin
            n_err++;
            $display("[TB] FAIL idle_after_10 got jkqebr=%b required 000001",
                     {j, k, exp_q, err, busy, cmd_bus.cmd_ready});
        end
    endtask

    task automatic test_set_toggle();
        logic [9:0] jk_seq = 10'b10_11_11_11_01;
        logic [4:0] q_seq  = 5'b10100;
        bit         found  = 0;
        do_reset();
        drv_q.push_back({SET, 4'd0});
        drv_q.push_back({TOGGLE, 4'd2});
        drv_q.push_back({RESET, 4'd0});
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (m_j && !m_k) found = 1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("[TB] FAIL set_start_timeout got no SET drive required SET within 20 cycles");
        end
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cycle();
            if (i < 5) begin
                n_vec++;
                if ({j, k} !== jk_seq[9-2*i -: 2]) begin
                    n_err++;
                    $display("[TB] FAIL seq_jk step=%0d got %b required %b", i, {j, k}, jk_seq[9-2*i -: 2]);
                end
            end
            if (i > 0) begin
                n_vec++;
                if (exp_q !== q_seq[5-i]) begin
                    n_err++;
                    $display("[TB] FAIL seq_exp_q step=%0d got %b required %b", i, exp_q, q_seq[5-i]);
                end
            end
        end
        n_vec++;
        if (err !== 1'b0 || err_cnt !== 8'd0) begin
            n_err++;
            $display("[TB] FAIL seq_err got err=%b cnt=%0d required 0 0", err, err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int total, active, first_c, last_c, accepted;
        bit done;
        logic [1:0] o;
        logic [3:0] l;
        do_reset();
        drv_q.push_back({TOGGLE, 4'd7});
        total = 8;
        for (int i = 0; i < 5; i++) begin
            o = 2'($urandom_range(1, 3));
            l = 4'($urandom_range(0, 3));
            drv_q.push_back({o, l});
            total += int'(l) + 1;
        end
        active = 0; first_c = -1; last_c = -1; accepted = 0; done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            cycle();
            if (m_accept) accepted++;
            n_vec++;
            if ({j, k, exp_q, err, busy, cmd_bus.cmd_ready, err_cnt} !==
                {m_j, m_k, m_exp, m_err, m_busy, m_ready, m_cnt}) begin
                n_err++;
                $display("[TB] FAIL b2b_model cyc=%0d got jkqebr=%b cnt=%0d required jkqebr=%b cnt=%0d",
                         cyc, {j, k, exp_q, err, busy, cmd_bus.cmd_ready}, err_cnt,
                         {m_j, m_k, m_exp, m_err, m_busy, m_ready}, m_cnt);
            end
            if (m_accept && accepted == 5) begin
                n_vec++;
                if (cmd_bus.cmd_ready !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL full_ready got %b required 0", cmd_bus.cmd_ready);
                end
            end
            if ((j | k) === 1'b1) begin
                active++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (c > 10 && drv_q.size() == 0 && mq.size() == 0 && !m_busy) done = 1;
        end
        n_vec++;
        if (!done || active != total || (last_c - first_c + 1) != total) begin
            n_err++;
            $display("[TB] FAIL b2b_span got active=%0d span=%0d done=%0d required %0d %0d 1",
                     active, last_c - first_c + 1, done, total, total);
        end
    endtask

    task automatic test_fault();
        bit found = 0;
        do_reset();
        drv_q.push_back({SET, 4'd3});
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (m_j && !m_k) found = 1;
        end
        force_en  = 1'b1;
        force_val = 1'b0;
        cycle();
        n_vec++;
        if (err !== 1'b1 || err_cnt !== 8'd1) begin
            n_err++;
            $display("[TB] FAIL fault_first got err=%b cnt=%0d required 1 1", err, err_cnt);
        end
        for (int i = 0; i < 3; i++) cycle();
        force_en = 1'b0;
        n_vec++;
        if (err_cnt !== 8'd4) begin
            n_err++;
            $display("[TB] FAIL fault_count got %0d required 4", err_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_vec++;
            if ({j, k, exp_q, err, busy, cmd_bus.cmd_ready, err_cnt} !==
                {m_j, m_k, m_exp, m_err, m_busy, m_ready, m_cnt}) begin
                n_err++;
                $display("[TB] FAIL fault_model cyc=%0d got jkqebr=%b cnt=%0d required jkqebr=%b cnt=%0d",
                         cyc, {j, k, exp_q, err, busy, cmd_bus.cmd_ready}, err_cnt,
                         {m_j, m_k, m_exp, m_err, m_busy, m_ready}, m_cnt);
            end
        end
        n_vec++;
        if (err !== 1'b1 || err_cnt !== 8'd4) begin
            n_err++;
            $display("[TB] FAIL fault_sticky got err=%b cnt=%0d required 1 4", err, err_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        force_en  = 1'b1;
        force_val = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cycle();
            n_vec++;
            if ({err, err_cnt} !== {m_err, m_cnt}) begin
                n_err++;
                $display("[TB] FAIL sat_model cyc=%0d got err=%b cnt=%0d required err=%b cnt=%0d",
                         cyc, err, err_cnt, m_err, m_cnt);
            end
        end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (err !== 1'b1 || err_cnt !== 8'd255) begin
                n_err++;
                $display("[TB] FAIL sat_hold got err=%b cnt=%0d required 1 255", err, err_cnt);
            end
            cycle();
        end
        force_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        do_reset();
        drv_q.push_back({TOGGLE, 4'd15});
        drv_q.push_back({SET, 4'd3});
        drv_q.push_back({RESET, 4'd2});
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (m_j && m_k) found = 1;
        end
        for (int i = 0; i < 4; i++) cycle();
        cl = 1'b0;
        drv_q.delete();
        cmd_bus.cmd_valid = 1'b0;
        cycle();
        n_vec++;
        if ({j, k, exp_q, busy, cmd_bus.cmd_ready} !== 5'b00000 || !found) begin
            n_err++;
            $display("[TB] FAIL mid_reset got jkqbr=%b found=%0d required 00000 1",
                     {j, k, exp_q, busy, cmd_bus.cmd_ready}, found);
        end
        cl = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            n_vec++;
            if ({j, k, busy, err} !== 4'b0000) begin
                n_err++;
                $display("[TB] FAIL mid_release cyc=%0d got jkbe=%b required 0000",
                         cyc, {j, k, busy, err});
            end
        end
    endtask

    task automatic test_random();
        int  issued = 0;
        int  gap    = 0;
        bit  done   = 0;
        do_reset();
        for (int c = 0; c < 3000 && !done; c++) begin
            if (issued < 25 && gap == 0) begin
                drv_q.push_back({2'($urandom_range(0, 3)), 4'($urandom_range(0, 4))});
                issued++;
                gap = $urandom_range(0, 3);
            end else if (gap > 0) begin
                gap--;
            end
            force_val = 1'($urandom_range(0, 1));
            force_en  = ($urandom_range(0, 15) == 0);
            cycle();
            n_vec++;
            if ({j, k, exp_q, err, busy, cmd_bus.cmd_ready, err_cnt} !==
                {m_j, m_k, m_exp, m_err, m_busy, m_ready, m_cnt}) begin
                n_err++;
                $display("[TB] FAIL rand_model cyc=%0d got jkqebr=%b cnt=%0d required jkqebr=%b cnt=%0d",
                         cyc, {j, k, exp_q, err, busy, cmd_bus.cmd_ready}, err_cnt,
                         {m_j, m_k, m_exp, m_err, m_busy, m_ready}, m_cnt);
            end
            if (issued == 25 && drv_q.size() == 0 && mq.size() == 0 && !m_busy) done = 1;
        end
        force_en = 1'b0;
        n_vec++;
        if (!done) begin
            n_err++;
            $display("[TB] FAIL rand_drain got not drained required drained within 3000 cycles");
        end
    endtask

    initial begin
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = HOLD;
        cmd_bus.cmd_len   = '0;
        test_reset();
        test_set_toggle();
        test_back_to_back();
        test_fault();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got no finish required finish before 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
